// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_pkg
// Description : Shared constants for the instruction-fetch slice.
//               PC_RESET - reset PC and base of the instruction ROM window.
//               IM_WORDS - number of 32-bit words in the ROM window.
//               npc_sel_e - next-PC source encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

   localparam logic [31:0] PC_RESET = 32'h0000_3000;
   localparam int unsigned IM_WORDS = 4096;

   typedef enum logic [1:0] {
      NPC_SEQ = 2'd0,
      NPC_BR  = 2'd1,
      NPC_J   = 2'd2,
      NPC_JR  = 2'd3
   } npc_sel_e;

endpackage
`default_nettype wire

// File: rtl/fetch_pc_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pc_if
// Description : Fetch-stage bus between the pipeline/ROM side (master) and the
//               fetch unit (slave).
//               master drives : stall, flush, npc_sel, id_pc, imm16, index26,
//                               jr_addr, im_data
//               slave drives  : im_addr, pc_f, instr_d, pc_d, err_d
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_pc_if;

   logic        stall;
   logic        flush;
   logic [1:0]  npc_sel;
   logic [31:0] id_pc;
   logic [15:0] imm16;
   logic [25:0] index26;
   logic [31:0] jr_addr;
   logic [31:0] im_data;
   logic [31:0] im_addr;
   logic [31:0] pc_f;
   logic [31:0] instr_d;
   logic [31:0] pc_d;
   logic        err_d;

   modport master (
      output stall, flush, npc_sel, id_pc, imm16, index26, jr_addr, im_data,
      input  im_addr, pc_f, instr_d, pc_d, err_d
   );

   modport slave (
      input  stall, flush, npc_sel, id_pc, imm16, index26, jr_addr, im_data,
      output im_addr, pc_f, instr_d, pc_d, err_d
   );

endinterface
`default_nettype wire

// File: rtl/npc_calc.sv
`default_nettype none
// ============================================================================
// Module      : npc_calc
// Description : Combinational next-PC selector.
//               i_pc_f    - current fetch PC (sequential source)
//               i_id_pc   - PC of the instruction in ID (branch/jump base)
//               i_imm16   - branch word offset
//               i_index26 - jump word index
//               i_jr_addr - register jump target
//               i_npc_sel - source select (mips_pkg::npc_sel_e)
//               o_npc     - next fetch PC
// Revision    : 1.0 - initial release
// ============================================================================
module npc_calc
   import mips_pkg::*;
(
   input  wire logic [31:0] i_pc_f,
   input  wire logic [31:0] i_id_pc,
   input  wire logic [15:0] i_imm16,
   input  wire logic [25:0] i_index26,
   input  wire logic [31:0] i_jr_addr,
   input  wire logic [1:0]  i_npc_sel,
   output logic      [31:0] o_npc
);

   logic [31:0] w_id_pc4;
   logic [31:0] w_br_off;

   // Branch and jump targets are relative to the delay-slot address (id_pc+4).
   assign w_id_pc4 = i_id_pc + 32'd4;
   assign w_br_off = {{14{i_imm16[15]}}, i_imm16, 2'b00};

   always_comb begin
      o_npc = i_pc_f + 32'd4;
      case (i_npc_sel)
         NPC_SEQ: o_npc = i_pc_f + 32'd4;
         NPC_BR:  o_npc = w_id_pc4 + w_br_off;
         NPC_J:   o_npc = {w_id_pc4[31:28], i_index26, 2'b00};
         NPC_JR:  o_npc = i_jr_addr;
         default: o_npc = i_pc_f + 32'd4;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/fetch_pc.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pc
// Description : Instruction-fetch stage: fetch PC register, next-PC select and
//               the IF/ID pipeline register.
//               clk   - system clock
//               reset - synchronous active-high reset
//               bus   - fetch_pc_if.slave (control, ROM data, IF/ID outputs)
//               Fetches outside the ROM window or misaligned do not stop fetch;
//               they insert a NOP flagged with err_d.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_pc #(
   parameter logic [31:0] PC_RESET = mips_pkg::PC_RESET,
   parameter int unsigned IM_WORDS = mips_pkg::IM_WORDS
) (
   input wire logic  clk,
   input wire logic  reset,
   fetch_pc_if.slave bus
);

   import mips_pkg::*;

   // Window bounds held in 33 bits so the upper limit cannot overflow.
   localparam logic [32:0] c_win_lo = {1'b0, PC_RESET};
   localparam logic [32:0] c_win_hi = {1'b0, PC_RESET} + (33'(IM_WORDS) << 2);

   logic [31:0] r_pc_f;
   logic [31:0] r_pc_d;
   logic [31:0] r_instr_d;
   logic        r_err_d;
   logic [31:0] w_npc;
   logic        w_fetch_err;

   npc_calc u_npc_calc (
      .i_pc_f    (r_pc_f),
      .i_id_pc   (bus.id_pc),
      .i_imm16   (bus.imm16),
      .i_index26 (bus.index26),
      .i_jr_addr (bus.jr_addr),
      .i_npc_sel (bus.npc_sel),
      .o_npc     (w_npc)
   );

   assign w_fetch_err = (r_pc_f[1:0] != 2'b00)
                     || ({1'b0, r_pc_f} <  c_win_lo)
                     || ({1'b0, r_pc_f} >= c_win_hi);

   // Priority: reset, stall (freezes everything), flush, normal.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_pc_f    <= PC_RESET;
         r_pc_d    <= PC_RESET;
         r_instr_d <= 32'h0;
         r_err_d   <= 1'b0;
      end else if (!bus.stall) begin
         r_pc_f <= w_npc;
         r_pc_d <= r_pc_f;
         if (bus.flush) begin
            r_instr_d <= 32'h0;
            r_err_d   <= 1'b0;
         end else begin
            r_instr_d <= w_fetch_err ? 32'h0 : bus.im_data;
            r_err_d   <= w_fetch_err;
         end
      end
   end

   assign bus.im_addr = r_pc_f;
   assign bus.pc_f    = r_pc_f;
   assign bus.pc_d    = r_pc_d;
   assign bus.instr_d = r_instr_d;
   assign bus.err_d   = r_err_d;

endmodule
`default_nettype wire

// File: tb/tb_fetch_pc.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_pc
// Description : Self-checking bench for fetch_pc: directed vectors followed by
//               randomized control/data against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_pc;

   localparam logic [31:0] c_pc_reset = 32'h0000_3000;
   localparam longint      c_win_end  = 64'h3000 + 4 * 4096;

   logic clk;
   logic reset;

   fetch_pc_if bus ();

   fetch_pc dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec;
   int n_bad;

   // Reference state
   logic [31:0] m_pc;
   logic [31:0] m_pc_d;
   logic [31:0] m_instr;
   logic        m_err;
   bit          m_valid;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic bit model_err(input logic [31:0] pc);
      longint p;
      p = longint'(pc);
      return ((p % 4) != 0) || (p < longint'(c_pc_reset)) || (p >= c_win_end);
   endfunction

   function automatic logic [31:0] model_npc(input logic [31:0] pc, input logic [1:0] sel,
                                             input logic [31:0] idpc, input logic [15:0] imm,
                                             input logic [25:0] idx, input logic [31:0] jr);
      logic [31:0] slot;
      int          off;
      slot = idpc + 32'd4;
      case (sel)
         2'd0:    return pc + 32'd4;
         2'd1: begin
            off = int'($signed(imm)) * 4;
            return slot + 32'(off);
         end
         2'd2:    return {slot[31:28], idx, 2'b00};
         default: return jr;
      endcase
   endfunction

   // One clock: drive inputs, advance the model, clock, compare outputs.
   task automatic cyc(input logic rs, input logic st, input logic fl, input logic [1:0] sel,
                      input logic [31:0] idpc, input logic [15:0] imm, input logic [25:0] idx,
                      input logic [31:0] jr, input logic [31:0] imd);
      logic [31:0] nxt;
      bit          e;
      reset       = rs;
      bus.stall   = st;
      bus.flush   = fl;
      bus.npc_sel = sel;
      bus.id_pc   = idpc;
      bus.imm16   = imm;
      bus.index26 = idx;
      bus.jr_addr = jr;
      bus.im_data = imd;
      #1;
      if (m_valid) check("im_addr", bus.im_addr, m_pc);
      if (rs) begin
         m_pc = c_pc_reset; m_pc_d = c_pc_reset; m_instr = 32'h0; m_err = 1'b0;
         m_valid = 1'b1;
      end else if (!st) begin
         nxt    = model_npc(m_pc, sel, idpc, imm, idx, jr);
         e      = model_err(m_pc);
         m_pc_d = m_pc;
         if (fl) begin
            m_instr = 32'h0; m_err = 1'b0;
         end else begin
            m_instr = e ? 32'h0 : imd; m_err = e;
         end
         m_pc = nxt;
      end
      @(posedge clk);
      #1;
      if (m_valid) begin
         check("pc_f",    bus.pc_f,    m_pc);
         check("pc_d",    bus.pc_d,    m_pc_d);
         check("instr_d", bus.instr_d, m_instr);
         check("err_d",   {31'h0, bus.err_d}, {31'h0, m_err});
      end
   endtask

   task automatic seq(input logic [31:0] imd);
      cyc(1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 16'h0, 26'h0, 32'h0, imd);
   endtask

   task automatic jr_to(input logic [31:0] tgt, input logic [31:0] imd);
      cyc(1'b0, 1'b0, 1'b0, 2'd3, 32'h0, 16'h0, 26'h0, tgt, imd);
   endtask

   initial begin
      logic [31:0] held_pc, held_pcd, held_ins;
      n_vec = 0; n_bad = 0; m_valid = 1'b0;
      m_pc = '0; m_pc_d = '0; m_instr = '0; m_err = 1'b0;

      // Reset with other controls active
      cyc(1'b1, 1'b1, 1'b1, 2'd2, 32'h1234, 16'h5, 26'h7, 32'h9, 32'hDEAD_BEEF);
      cyc(1'b1, 1'b0, 1'b0, 2'd0, 32'h0, 16'h0, 26'h0, 32'h0, 32'h0);
      check("rst_pc_f",  bus.pc_f,    32'h3000);
      check("rst_pc_d",  bus.pc_d,    32'h3000);
      check("rst_instr", bus.instr_d, 32'h0);

      // Sequential fetch
      seq(32'h1111_0001); check("seq1", bus.pc_f, 32'h3004); check("seq1_d", bus.pc_d, 32'h3000);
      seq(32'h1111_0002); check("seq2", bus.pc_f, 32'h3008); check("seq2_ins", bus.instr_d, 32'h1111_0002);
      seq(32'h1111_0003); check("seq3", bus.pc_f, 32'h300C); check("seq3_d", bus.pc_d, 32'h3008);

      // Branch back / forward, jump, register jump
      cyc(1'b0, 1'b0, 1'b0, 2'd1, 32'h3010, 16'hFFFC, 26'h0, 32'h0, 32'h2222_0000);
      check("br_back", bus.pc_f, 32'h3004);
      cyc(1'b0, 1'b0, 1'b0, 2'd1, 32'h3010, 16'h0003, 26'h0, 32'h0, 32'h2222_0001);
      check("br_fwd", bus.pc_f, 32'h3020);
      cyc(1'b0, 1'b0, 1'b0, 2'd2, 32'h3010, 16'h0, 26'h0000C10, 32'h0, 32'h2222_0002);
      check("jump", bus.pc_f, 32'h3040);
      jr_to(32'h3100, 32'h2222_0003);
      check("jr", bus.pc_f, 32'h3100);

      // Stall with redirect and flush requested: everything holds
      held_pc = bus.pc_f; held_pcd = bus.pc_d; held_ins = bus.instr_d;
      for (int i = 0; i < 2; i++) begin
         cyc(1'b0, 1'b1, 1'b1, 2'd1, 32'h3010, 16'h0040, 26'h0, 32'h0, 32'h3333_0000);
         check("stall_pc",  bus.pc_f,    held_pc);
         check("stall_pcd", bus.pc_d,    held_pcd);
         check("stall_ins", bus.instr_d, held_ins);
      end
      seq(32'h3333_0001);
      check("resume_pcd", bus.pc_d, 32'h3100);
      check("resume_pc",  bus.pc_f, 32'h3104);

      // Flush: NOP enters IF/ID, PC still advances
      cyc(1'b0, 1'b0, 1'b1, 2'd0, 32'h0, 16'h0, 26'h0, 32'h0, 32'h4444_0000);
      check("flush_ins", bus.instr_d, 32'h0);
      check("flush_pcd", bus.pc_d,    32'h3104);

      // Fetch-error cases
      jr_to(32'h3002, 32'h5555_0000);
      jr_to(32'h7000, 32'h5555_0001);
      check("mis_err", {31'h0, bus.err_d}, 32'h1); check("mis_ins", bus.instr_d, 32'h0);
      jr_to(32'h6FFC, 32'h5555_0002);
      check("hi_err", {31'h0, bus.err_d}, 32'h1); check("hi_ins", bus.instr_d, 32'h0);
      seq(32'h5555_0003);
      check("last_err", {31'h0, bus.err_d}, 32'h0); check("last_ins", bus.instr_d, 32'h5555_0003);

      // Address wrap at the top of the space
      jr_to(32'hFFFF_FFFC, 32'h6666_0000);
      seq(32'h6666_0001);
      check("wrap", bus.pc_f, 32'h0);

      // Reset during stall
      jr_to(32'h3040, 32'h7777_0000);
      cyc(1'b1, 1'b1, 1'b0, 2'd1, 32'h3010, 16'h0010, 26'h0, 32'h0, 32'h7777_0001);
      check("rst_stall_pc",  bus.pc_f,    32'h3000);
      check("rst_stall_ins", bus.instr_d, 32'h0);

      // Randomized traffic
      for (int i = 0; i < 1500; i++) begin
         logic        rs, st, fl;
         logic [1:0]  sel;
         logic [31:0] idpc, jr;
         rs   = ($urandom_range(0, 99) < 2);
         st   = ($urandom_range(0, 99) < 20);
         fl   = ($urandom_range(0, 99) < 15);
         sel  = 2'($urandom_range(0, 3));
         idpc = 32'h3000 + 32'($urandom_range(0, 32'h4000));
         if ($urandom_range(0, 9) == 0) idpc = $urandom;
         jr   = 32'h2FF0 + 32'($urandom_range(0, 32'h4020));
         if ($urandom_range(0, 9) == 0) jr = $urandom;
         cyc(rs, st, fl, sel, idpc, 16'($urandom), 26'($urandom), jr, $urandom);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
